// File: rtl/bp_update_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_sched_if
// Brief    : Commit-lane input bus and predictor update bus for bp_update_sched.
//            master = scheduler view, slave = commit/predictor environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface bp_update_sched_if;
    logic        in0_valid;
    logic        in0_taken;
    logic [6:0]  in0_opcode;
    logic [31:0] in0_pc;
    logic [31:0] in0_pc_next;
    logic        in1_valid;
    logic        in1_taken;
    logic [6:0]  in1_opcode;
    logic [31:0] in1_pc;
    logic [31:0] in1_pc_next;
    logic        in_ready;
    logic        upd_valid;
    logic        upd_ready;
    logic        upd_taken;
    logic [6:0]  upd_opcode;
    logic [31:0] upd_pc;
    logic [31:0] upd_pc_next;
    logic [15:0] drop_cnt;

    modport master (
        input  in0_valid, in0_taken, in0_opcode, in0_pc, in0_pc_next,
        input  in1_valid, in1_taken, in1_opcode, in1_pc, in1_pc_next,
        input  upd_ready,
        output in_ready, upd_valid, upd_taken, upd_opcode, upd_pc, upd_pc_next,
        output drop_cnt
    );

    modport slave (
        output in0_valid, in0_taken, in0_opcode, in0_pc, in0_pc_next,
        output in1_valid, in1_taken, in1_opcode, in1_pc, in1_pc_next,
        output upd_ready,
        input  in_ready, upd_valid, upd_taken, upd_opcode, upd_pc, upd_pc_next,
        input  drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_sched
// Brief    : Buffers up to two retired control-flow updates per cycle and drains
//            them one per cycle to the predictor update port.
//            Optional macro BP_UPD_COALESCE_EN merges same-pc updates in place.
// Revision : 1.0 - initial release
// ============================================================================
module bp_update_sched #(
    parameter int         DEPTH_LOG2  = 3,
    parameter logic [6:0] BR_OPCODE   = 7'h63,
    parameter logic [6:0] JAL_OPCODE  = 7'h6F,
    parameter logic [6:0] JALR_OPCODE = 7'h67
) (
    input  logic              clk,
    input  logic              rst,
    bp_update_sched_if.master bus
);

    typedef struct packed {
        logic        taken;
        logic [6:0]  opcode;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } entry_t;

    localparam int                    c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_READY_MAX = (DEPTH_LOG2 + 1)'(c_DEPTH - 2);
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);

    entry_t                r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_head;
    logic [DEPTH_LOG2-1:0] r_tail;
    logic [DEPTH_LOG2:0]   r_count;
    logic [15:0]           r_drop_cnt;

    logic                  w_in_ready;
    logic                  w_upd_valid;
    logic                  w_pop;
    logic                  w_acc0;
    logic                  w_acc1;
    logic                  w_merge0;
    logic                  w_merge1;
    logic                  w_alloc0;
    logic                  w_alloc1;
    logic [DEPTH_LOG2-1:0] w_tail_p1;
    logic [DEPTH_LOG2-1:0] w_idx0;
    logic [DEPTH_LOG2-1:0] w_idx1;
    logic [DEPTH_LOG2-1:0] w_tail_next;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [1:0]            w_drop_n;
    logic [16:0]           w_drop_sum;
    entry_t                w_ent0;
    entry_t                w_ent1;
    entry_t                w_head_ent;

    function automatic logic is_cf(input logic [6:0] op);
        return (op == BR_OPCODE) || (op == JAL_OPCODE) || (op == JALR_OPCODE);
    endfunction

    // Readiness looks only at the registered count; a same-cycle pop gives no credit.
    assign w_in_ready  = (r_count <= c_READY_MAX);
    assign w_upd_valid = (r_count != '0);
    assign w_pop       = w_upd_valid && bus.upd_ready;
    assign w_acc0      = w_in_ready && bus.in0_valid && is_cf(bus.in0_opcode);
    assign w_acc1      = w_in_ready && bus.in1_valid && is_cf(bus.in1_opcode);
    assign w_ent0      = {bus.in0_taken, bus.in0_opcode, bus.in0_pc, bus.in0_pc_next};
    assign w_ent1      = {bus.in1_taken, bus.in1_opcode, bus.in1_pc, bus.in1_pc_next};
    assign w_tail_p1   = r_tail + c_PTR_ONE;

`ifdef BP_UPD_COALESCE_EN
    localparam logic [DEPTH_LOG2:0] c_CNT_TWO = (DEPTH_LOG2 + 1)'(2);

    logic [DEPTH_LOG2-1:0] w_last;
    logic                  w_merge_ok;

    // The newest entry may only be rewritten if the head pop cannot be taking it.
    assign w_last     = r_tail - c_PTR_ONE;
    assign w_merge_ok = (r_count >= c_CNT_TWO) || ((r_count == c_CNT_ONE) && !w_pop);
    assign w_merge0   = w_acc0 && w_merge_ok && (r_mem[w_last].pc == bus.in0_pc);
    assign w_merge1   = w_acc1 && (w_acc0 ? (bus.in1_pc == bus.in0_pc)
                                          : (w_merge_ok && (r_mem[w_last].pc == bus.in1_pc)));
    assign w_idx0     = w_merge0 ? w_last : r_tail;
    assign w_idx1     = w_merge1 ? (w_alloc0 ? r_tail : w_last)
                                 : (w_alloc0 ? w_tail_p1 : r_tail);
`else
    assign w_merge0   = 1'b0;
    assign w_merge1   = 1'b0;
    assign w_idx0     = r_tail;
    assign w_idx1     = w_alloc0 ? w_tail_p1 : r_tail;
`endif

    assign w_alloc0 = w_acc0 && !w_merge0;
    assign w_alloc1 = w_acc1 && !w_merge1;

    always_comb begin
        w_tail_next  = r_tail;
        w_count_next = r_count;
        if (w_alloc0) begin
            w_tail_next  = w_tail_next + c_PTR_ONE;
            w_count_next = w_count_next + c_CNT_ONE;
        end
        if (w_alloc1) begin
            w_tail_next  = w_tail_next + c_PTR_ONE;
            w_count_next = w_count_next + c_CNT_ONE;
        end
        if (w_pop) begin
            w_count_next = w_count_next - c_CNT_ONE;
        end
    end

    assign w_drop_n   = w_in_ready ? 2'd0
                                   : ({1'b0, bus.in0_valid} + {1'b0, bus.in1_valid});
    assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_n};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            r_tail     <= w_tail_next;
            r_count    <= w_count_next;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    // Lane 1 is written last so a same-slot collision keeps the younger data.
    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_mem[w_idx0] <= w_ent0;
        end
        if (w_acc1) begin
            r_mem[w_idx1] <= w_ent1;
        end
    end

    assign w_head_ent      = w_upd_valid ? r_mem[r_head] : '0;
    assign bus.in_ready    = w_in_ready;
    assign bus.upd_valid   = w_upd_valid;
    assign bus.upd_taken   = w_head_ent.taken;
    assign bus.upd_opcode  = w_head_ent.opcode;
    assign bus.upd_pc      = w_head_ent.pc;
    assign bus.upd_pc_next = w_head_ent.pc_next;
    assign bus.drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_sched
// Brief    : Directed plus randomised bench for bp_update_sched with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_update_sched;

    localparam int         c_DEPTH = 8;
    localparam logic [6:0] c_BR    = 7'h63;
    localparam logic [6:0] c_JAL   = 7'h6F;
    localparam logic [6:0] c_JALR  = 7'h67;
    localparam logic [6:0] c_OP    = 7'h33;
`ifdef BP_UPD_COALESCE_EN
    localparam bit         c_COAL  = 1'b1;
`else
    localparam bit         c_COAL  = 1'b0;
`endif

    typedef struct {
        bit        taken;
        bit [6:0]  op;
        bit [31:0] pc;
        bit [31:0] pcn;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    ent_t q[$];
    int   m_drop;

    bp_update_sched_if bus ();

    bp_update_sched #(.DEPTH_LOG2(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_cf(input bit [6:0] op);
        return (op == c_BR) || (op == c_JAL) || (op == c_JALR);
    endfunction

    // Reference model: plain queue, one step per rising edge.
    function automatic void put(input ent_t e, input bit allow);
        if (c_COAL && allow && (q.size() > 0) && (q[$].pc == e.pc)) q[$] = e;
        else q.push_back(e);
    endfunction

    int sz0;
    bit m_pop;
    bit m_rdy;
    bit m_allow;
    ent_t e0;
    ent_t e1;
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_drop = 0;
        end else begin
            sz0     = q.size();
            m_pop   = (sz0 > 0) && bus.upd_ready;
            m_rdy   = (sz0 <= c_DEPTH - 2);
            m_allow = (sz0 >= 2) || ((sz0 == 1) && !m_pop);
            e0 = '{bus.in0_taken, bus.in0_opcode, bus.in0_pc, bus.in0_pc_next};
            e1 = '{bus.in1_taken, bus.in1_opcode, bus.in1_pc, bus.in1_pc_next};
            if (!m_rdy) begin
                m_drop = m_drop + int'(bus.in0_valid) + int'(bus.in1_valid);
                if (m_drop > 16'hFFFF) m_drop = 16'hFFFF;
            end else begin
                if (bus.in0_valid && is_cf(bus.in0_opcode)) begin
                    put(e0, m_allow);
                    m_allow = 1'b1;
                end
                if (bus.in1_valid && is_cf(bus.in1_opcode)) put(e1, m_allow);
            end
            if (m_pop) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("upd_valid", 32'(bus.upd_valid), 32'(q.size() != 0));
            check("in_ready", 32'(bus.in_ready), 32'(q.size() <= c_DEPTH - 2));
            check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
            if (q.size() != 0) begin
                check("upd_taken", 32'(bus.upd_taken), 32'(q[0].taken));
                check("upd_opcode", 32'(bus.upd_opcode), 32'(q[0].op));
                check("upd_pc", bus.upd_pc, q[0].pc);
                check("upd_pc_next", bus.upd_pc_next, q[0].pcn);
            end
        end
    end

    task automatic drive0(input bit t, input bit [6:0] op, input bit [31:0] pc, input bit [31:0] pcn);
        bus.in0_valid = 1'b1; bus.in0_taken = t; bus.in0_opcode = op;
        bus.in0_pc = pc; bus.in0_pc_next = pcn;
    endtask

    task automatic drive1(input bit t, input bit [6:0] op, input bit [31:0] pc, input bit [31:0] pcn);
        bus.in1_valid = 1'b1; bus.in1_taken = t; bus.in1_opcode = op;
        bus.in1_pc = pc; bus.in1_pc_next = pcn;
    endtask

    task automatic idle();
        bus.in0_valid = 1'b0; bus.in0_taken = 1'b0; bus.in0_opcode = '0;
        bus.in0_pc = '0; bus.in0_pc_next = '0;
        bus.in1_valid = 1'b0; bus.in1_taken = 1'b0; bus.in1_opcode = '0;
        bus.in1_pc = '0; bus.in1_pc_next = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.upd_ready = 1'b0;
        idle();
        repeat (2) tick();
        check("rst upd_valid", 32'(bus.upd_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst drop_cnt", 32'(bus.drop_cnt), 32'd0);
        check("rst upd_pc", bus.upd_pc, 32'd0);
        check("rst upd_taken", 32'(bus.upd_taken), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // single taken branch right after reset
        drive0(1'b1, c_BR, 32'h100, 32'h80);
        tick(); idle();
        check("t1 upd_valid", 32'(bus.upd_valid), 32'd1);
        check("t1 upd_pc", bus.upd_pc, 32'h100);
        check("t1 upd_pc_next", bus.upd_pc_next, 32'h80);
        check("t1 upd_taken", 32'(bus.upd_taken), 32'd1);
        bus.upd_ready = 1'b1;
        tick();

        // two lanes, drained in lane order
        drive0(1'b1, c_JAL, 32'h200, 32'h400);
        drive1(1'b0, c_BR, 32'h204, 32'h208);
        tick(); idle();
        check("t2 first pc", bus.upd_pc, 32'h200);
        tick();
        check("t2 second pc", bus.upd_pc, 32'h204);
        check("t2 second taken", 32'(bus.upd_taken), 32'd0);
        tick();
        check("t2 drained", 32'(bus.upd_valid), 32'd0);

        // non control-flow lane 0 filtered out
        drive0(1'b0, c_OP, 32'h50, 32'h54);
        drive1(1'b1, c_JALR, 32'h10, 32'h3c);
        tick(); idle();
        check("t3 pc", bus.upd_pc, 32'h10);
        tick();
        check("t3 single entry", 32'(bus.upd_valid), 32'd0);

        // fill to full, overflow once, then drain across the wrap
        bus.upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive0(i[0], c_BR, 32'h1000 + 32'(8 * i), 32'h2000 + 32'(i));
            drive1(~i[0], c_JAL, 32'h1004 + 32'(8 * i), 32'h3000 + 32'(i));
            tick();
        end
        idle();
        check("t4 full in_ready", 32'(bus.in_ready), 32'd0);
        drive0(1'b1, c_BR, 32'h9000, 32'h9004);
        tick(); idle();
        check("t4 drop_cnt", 32'(bus.drop_cnt), 32'd1);
        bus.upd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t4 drain pc", bus.upd_pc, 32'h1000 + 32'(4 * k));
            tick();
        end
        check("t4 empty", 32'(bus.upd_valid), 32'd0);

        // reset mid-drain, then immediate accept
        bus.upd_ready = 1'b0;
        drive0(1'b1, c_BR, 32'h600, 32'h604);
        drive1(1'b1, c_JAL, 32'h608, 32'h60c);
        tick();
        drive0(1'b0, c_BR, 32'h610, 32'h614);
        bus.in1_valid = 1'b0;
        tick(); idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 upd_valid", 32'(bus.upd_valid), 32'd0);
        check("t5 in_ready", 32'(bus.in_ready), 32'd1);
        check("t5 drop_cnt", 32'(bus.drop_cnt), 32'd0);
        drive0(1'b1, c_BR, 32'h700, 32'h704);
        tick(); idle();
        check("t5 accept pc", bus.upd_pc, 32'h700);
        bus.upd_ready = 1'b1;
        tick();

        // repeated pc: merged under coalescing, three entries otherwise
        bus.upd_ready = 1'b0;
        drive0(1'b1, c_BR, 32'h300, 32'h280); tick();
        drive0(1'b1, c_BR, 32'h300, 32'h280); tick();
        drive0(1'b0, c_BR, 32'h300, 32'h280); tick();
        idle();
        check("t6 head taken", 32'(bus.upd_taken), c_COAL ? 32'd0 : 32'd1);
        bus.upd_ready = 1'b1;
        repeat (c_COAL ? 1 : 3) tick();
        check("t6 entry count", 32'(bus.upd_valid), 32'd0);

        // same pc on both lanes in one cycle
        bus.upd_ready = 1'b0;
        drive0(1'b1, c_JAL, 32'h500, 32'h600);
        drive1(1'b0, c_BR, 32'h500, 32'h504);
        tick(); idle();
        check("t7 head opcode", 32'(bus.upd_opcode), c_COAL ? 32'(c_BR) : 32'(c_JAL));
        check("t7 head pc_next", bus.upd_pc_next, c_COAL ? 32'h504 : 32'h600);
        bus.upd_ready = 1'b1;
        repeat (2) tick();

        // randomised mix against the model
        for (int n = 0; n < 300; n++) begin
            idle();
            bus.upd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                drive0($urandom_range(0, 1) == 1,
                       ($urandom_range(0, 4) == 0) ? c_OP : c_BR,
                       32'h400 + 32'(4 * $urandom_range(0, 2)), 32'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                drive1($urandom_range(0, 1) == 1,
                       ($urandom_range(0, 1) == 0) ? c_JAL : c_JALR,
                       32'h400 + 32'(4 * $urandom_range(0, 2)), 32'($urandom));
            end
            tick();
        end
        idle();
        bus.upd_ready = 1'b1;
        repeat (12) tick();
        check("final empty", 32'(bus.upd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
